spike_argmax_readout: RTL and testbench

Downstream of the spike counter on the output LIF layer. Accepts the raw output-layer spike vector and counts spikes per class over a fixed window of cycles. It then scans the counts one class per cycle and reports the winning class (argmax) and its count through a valid/ready result interface. This replaces the "expose one raw spike count on uo_out" readout with a classification result.

---
 rtl/spike_argmax_readout.sv | 163 ++++++++++++++++
 tb/tb_spike_argmax_readout.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_argmax_readout.sv
// Per-class spike accumulation over a fixed window, then a one-class-per-cycle argmax scan.
// Optional ARGMAX_MARGIN_EN adds margin_o (winner count minus runner-up count).
module spike_argmax_readout #(
    parameter int NUM_CLASSES   = 10,
    parameter int COUNT_W       = 8,
    parameter int WINDOW_CYCLES = 64,
    parameter int CLASS_W       = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [NUM_CLASSES-1:0] spike_i,
    output logic                   busy_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [CLASS_W-1:0]     class_o,
    output logic [COUNT_W-1:0]     max_count_o
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [COUNT_W-1:0]     margin_o
`endif
);

    // state   | meaning
    // S_IDLE  | waiting for start_i
    // S_ACCUM | counting spikes for WINDOW_CYCLES cycles
    // S_SCAN  | comparing one class counter per cycle
    // S_DONE  | result valid, waiting for ready_i
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCAN, S_DONE} state_t;

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CLASS_W-1:0] IDX_LAST = CLASS_W'(NUM_CLASSES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

    state_t                             state_q, state_d;
    logic [NUM_CLASSES-1:0][COUNT_W-1:0] cnt_q, cnt_d;
    logic [WIN_W-1:0]                   win_q, win_d;
    logic [CLASS_W-1:0]                 idx_q, idx_d;
    logic [CLASS_W-1:0]                 best_idx_q, best_idx_d;
    logic [CLASS_W-1:0]                 class_q, class_d;
    logic [COUNT_W-1:0]                 best_q, best_d;
    logic [COUNT_W-1:0]                 max_q, max_d;
    logic [COUNT_W-1:0]                 cur;
    logic                               start_win;
`ifdef ARGMAX_MARGIN_EN
    logic [COUNT_W-1:0]                 second_q, second_d;
    logic [COUNT_W-1:0]                 margin_q, margin_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        best_d     = best_q;
        class_d    = class_q;
        max_d      = max_q;
        cur        = cnt_q[idx_q];
        start_win  = 1'b0;
`ifdef ARGMAX_MARGIN_EN
        second_d   = second_q;
        margin_d   = margin_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                start_win = start_i;
            end
            S_ACCUM: begin
                for (int i = 0; i < NUM_CLASSES; i++) begin
                    if (spike_i[i] && (cnt_q[i] != CNT_MAX)) begin
                        cnt_d[i] = cnt_q[i] + COUNT_W'(1);
                    end
                end
                win_d = win_q + WIN_W'(1);
                if (win_q == WIN_LAST) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                // strict compare keeps the lowest index on ties
                if (idx_q == '0) begin
                    best_d     = cur;
                    best_idx_d = '0;
`ifdef ARGMAX_MARGIN_EN
                    second_d   = '0;
`endif
                end else if (cur > best_q) begin
                    best_d     = cur;
                    best_idx_d = idx_q;
`ifdef ARGMAX_MARGIN_EN
                    second_d   = best_q;
                end else if (cur > second_q) begin
                    second_d   = cur;
`endif
                end
                idx_d = idx_q + CLASS_W'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                    class_d = best_idx_d;
                    max_d   = best_d;
`ifdef ARGMAX_MARGIN_EN
                    margin_d = best_d - second_d;
`endif
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    state_d   = S_IDLE;
                    start_win = start_i;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (start_win) begin
            state_d = S_ACCUM;
            cnt_d   = '0;
            win_d   = '0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            win_q      <= '0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
            class_q    <= '0;
            max_q      <= '0;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= '0;
            margin_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_q     <= best_d;
            class_q    <= class_d;
            max_q      <= max_d;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= second_d;
            margin_q   <= margin_d;
`endif
        end
    end

    assign busy_o      = (state_q == S_ACCUM) || (state_q == S_SCAN);
    assign valid_o     = (state_q == S_DONE);
    assign class_o     = class_q;
    assign max_count_o = max_q;
`ifdef ARGMAX_MARGIN_EN
    assign margin_o    = margin_q;
`endif

endmodule

// File: tb/tb_spike_argmax_readout.sv
// Directed bench for spike_argmax_readout: default instance (W=64) plus a W=300 instance for saturation.
module tb_spike_argmax_readout;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, ready_a, start_b, ready_b;
    logic [9:0] spike_a, spike_b;
    logic       busy_a, valid_a, busy_b, valid_b;
    logic [3:0] class_a, class_b;
    logic [7:0] max_a, max_b;
`ifdef ARGMAX_MARGIN_EN
    logic [7:0] margin_a, margin_b;
`endif
    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    always #5 clk = ~clk;

    spike_argmax_readout dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .spike_i(spike_a),
        .busy_o(busy_a), .valid_o(valid_a), .ready_i(ready_a),
        .class_o(class_a), .max_count_o(max_a)
`ifdef ARGMAX_MARGIN_EN
        , .margin_o(margin_a)
`endif
    );

    spike_argmax_readout #(.WINDOW_CYCLES(300)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .spike_i(spike_b),
        .busy_o(busy_b), .valid_o(valid_b), .ready_i(ready_b),
        .class_o(class_b), .max_count_o(max_b)
`ifdef ARGMAX_MARGIN_EN
        , .margin_o(margin_b)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] spike_for(input int mode, input int c);
        logic [9:0] v;
        v = '0;
        case (mode)
            0: v[3] = 1'b1;
            1: begin
                v[2] = (c < 20);
                v[7] = (c >= 10) && (c < 30);
                v[0] = (c >= 40) && (c < 45);
            end
            2: begin
                v[5] = 1'b1;
                v[1] = (c < 100);
            end
            3: v[9] = 1'b1;
            4: begin
                v[8] = (c < 12);
                v[1] = (c < 5);
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    // start (with ready=rdy), drive w spike cycles, wait for valid; lat = edges after the start edge
    task automatic classify(input int sel, input int mode, input int w, input logic rdy,
                            input int prev_cls, input int prev_max, output int lat_o);
        @(negedge clk);
        if (sel == 0) begin start_a = 1'b1; ready_a = rdy; end
        else          begin start_b = 1'b1; ready_b = rdy; end
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
        lat_o = 0;
        check_val("busy_after_start",  (sel == 0) ? busy_a  : busy_b,  1);
        check_val("valid_after_start", (sel == 0) ? valid_a : valid_b, 0);
        check_val("class_held",        (sel == 0) ? class_a : class_b, prev_cls);
        check_val("max_held",          (sel == 0) ? max_a   : max_b,   prev_max);
        for (int c = 0; c < w; c++) begin
            if (sel == 0) spike_a = spike_for(mode, c);
            else          spike_b = spike_for(mode, c);
            @(negedge clk);
            lat_o++;
        end
        spike_a = '0;
        spike_b = '0;
        while (!((sel == 0) ? valid_a : valid_b) && lat_o < w + 40) begin
            @(negedge clk);
            lat_o++;
        end
        check_val("valid_rise", (sel == 0) ? valid_a : valid_b, 1);
        check_val("no_busy_with_valid", (sel == 0) ? busy_a : busy_b, 0);
    endtask

    task automatic release_a(input int cls, input int mx);
        @(negedge clk);
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        check_val("idle_valid", valid_a, 0);
        check_val("idle_busy",  busy_a,  0);
        check_val("idle_class_hold", class_a, cls);
        check_val("idle_max_hold",   max_a,   mx);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; ready_a = 1'b0; spike_a = '0;
        start_b = 1'b0; ready_b = 1'b0; spike_b = '0;

        // reset with random activity on the inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            spike_a = 10'($urandom);
            start_a = 1'($urandom);
        end
        @(negedge clk);
        check_val("rst_busy",  busy_a,  0);
        check_val("rst_valid", valid_a, 0);
        check_val("rst_class", class_a, 0);
        check_val("rst_max",   max_a,   0);
        rst = 1'b0; spike_a = '0; start_a = 1'b0;

        // single winner, latency W+N edges after the start edge
        classify(0, 0, 64, 1'b0, 0, 0, lat);
        check_val("single_latency", lat, 74);
        check_val("single_class", class_a, 3);
        check_val("single_max",   max_a,   64);
`ifdef ARGMAX_MARGIN_EN
        check_val("single_margin", margin_a, 64);
`endif
        release_a(3, 64);

        // tie between classes 2 and 7
        classify(0, 1, 64, 1'b0, 3, 64, lat);
        check_val("tie_latency", lat, 74);
        check_val("tie_class", class_a, 2);
        check_val("tie_max",   max_a,   20);
`ifdef ARGMAX_MARGIN_EN
        check_val("tie_margin", margin_a, 0);
`endif

        // backpressure: start pulses are ignored while ready is low
        for (int i = 0; i < 10; i++) begin
            start_a = (i % 2 == 0);
            @(negedge clk);
            check_val("bp_valid", valid_a, 1);
            check_val("bp_busy",  busy_a,  0);
            check_val("bp_class", class_a, 2);
            check_val("bp_max",   max_a,   20);
        end
        start_a = 1'b0;

        // ready+start together restarts directly; new window must not see old counts
        classify(0, 4, 64, 1'b1, 2, 20, lat);
        check_val("restart_latency", lat, 74);
        check_val("restart_class", class_a, 8);
        check_val("restart_max",   max_a,   12);
`ifdef ARGMAX_MARGIN_EN
        check_val("restart_margin", margin_a, 7);
`endif
        release_a(8, 12);

        // reset in the middle of ACCUM
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 30; c++) begin
            spike_a = 10'h004;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        spike_a = '0;
        check_val("midrst_busy",  busy_a,  0);
        check_val("midrst_valid", valid_a, 0);
        check_val("midrst_class", class_a, 0);
        check_val("midrst_max",   max_a,   0);
        classify(0, 3, 64, 1'b0, 0, 0, lat);
        check_val("post_rst_latency", lat, 74);
        check_val("post_rst_class", class_a, 9);
        check_val("post_rst_max",   max_a,   64);
        release_a(9, 64);

        // no spikes at all
        classify(0, 5, 64, 1'b0, 9, 64, lat);
        check_val("zero_class", class_a, 0);
        check_val("zero_max",   max_a,   0);
`ifdef ARGMAX_MARGIN_EN
        check_val("zero_margin", margin_a, 0);
`endif
        release_a(0, 0);

        // saturation on the long-window instance
        classify(1, 2, 300, 1'b0, 0, 0, lat);
        check_val("sat_latency", lat, 310);
        check_val("sat_class", class_b, 5);
        check_val("sat_max",   max_b,   255);
`ifdef ARGMAX_MARGIN_EN
        check_val("sat_margin", margin_b, 155);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
